// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-ported memory between the instruction-fetch port and the
// load/store port. Only one access is outstanding at a time. The memory
// latency is fixed, and each result returns as a one-cycle valid pulse.
// Misaligned data accesses are granted, but they never reach the memory.
// Optional feature: define UMA_RR_ARB_EN to select round-robin arbitration
// in place of fixed data-over-fetch priority.
module unified_mem_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, ERR = 2'd2} state_t;

  localparam logic       OWN_IF   = 1'b0;
  localparam logic       OWN_D    = 1'b1;
  localparam logic [2:0] LAST_CNT = 3'(MEM_LATENCY - 1);

  // A half-word access must be 2-byte aligned. A word access must be 4-byte aligned.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    logic bad;
    case (size)
      2'b01:   bad = lsb[0];
      2'b10:   bad = (lsb != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  state_t     state_r, state_nx_s;
  logic       owner_r, owner_nx_s;
  logic       is_write_r, is_write_nx_s;
  logic [2:0] cnt_r, cnt_nx_s;
  logic       complete_s, ready_s, pick_d_s, gnt_d_s, gnt_if_s, misal_s;

  // A grant can land in the same cycle that the previous access completes.
  // While reset is asserted, nothing is granted, so every output stays 0.
  assign complete_s = (state_r == BUSY) && (cnt_r == LAST_CNT);
  assign ready_s    = rst && ((state_r == IDLE) || complete_s);
  assign misal_s    = misaligned(d_size, d_addr[1:0]);

`ifdef UMA_RR_ARB_EN
  logic rr_ptr_r;  // 1 = data port favoured on the next tie

  assign pick_d_s = d_req && (!if_req || rr_ptr_r);

  // On every grant, the pointer moves so that it favours the port that was just passed over.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= 1'b1;
    end else if (gnt_d_s) begin
      rr_ptr_r <= 1'b0;
    end else if (gnt_if_s) begin
      rr_ptr_r <= 1'b1;
    end
  end
`else
  assign pick_d_s = d_req;
`endif

  assign gnt_d_s  = ready_s && d_req && pick_d_s;
  assign gnt_if_s = ready_s && if_req && !pick_d_s;

  // State register: tracks the outstanding access (its owner, its type and its latency count).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      owner_r    <= OWN_D;
      is_write_r <= 1'b0;
      cnt_r      <= 3'd0;
    end else begin
      state_r    <= state_nx_s;
      owner_r    <= owner_nx_s;
      is_write_r <= is_write_nx_s;
      cnt_r      <= cnt_nx_s;
    end
  end

  // Next-state logic: selects the grant, drives the memory mux and produces the completion pulses.
  always_comb begin
    state_nx_s    = state_r;
    owner_nx_s    = owner_r;
    is_write_nx_s = is_write_r;
    cnt_nx_s      = cnt_r;
    if_gnt        = 1'b0;
    d_gnt         = 1'b0;
    if_rvalid     = 1'b0;
    if_rdata      = 32'h0000_0000;
    d_rvalid      = 1'b0;
    d_rdata       = 32'h0000_0000;
    d_err         = 1'b0;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_size      = 2'b00;
    mem_addr      = '0;
    mem_wdata     = 32'h0000_0000;

    if (complete_s) begin
      if (owner_r == OWN_D) begin
        d_rvalid = 1'b1;
        d_rdata  = is_write_r ? 32'h0000_0000 : mem_rdata;
      end else begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
    end else if (state_r == ERR) begin
      d_rvalid = 1'b1;
      d_err    = 1'b1;
    end else begin
      d_err = 1'b0;
    end

    case (state_r)
      IDLE: state_nx_s = IDLE;
      BUSY: begin
        if (complete_s) begin
          state_nx_s = IDLE;
        end else begin
          cnt_nx_s = cnt_r + 3'd1;
        end
      end
      ERR:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase

    if (gnt_d_s) begin
      d_gnt         = 1'b1;
      owner_nx_s    = OWN_D;
      is_write_nx_s = d_we;
      cnt_nx_s      = 3'd0;
      if (misal_s) begin
        state_nx_s = ERR;
      end else begin
        state_nx_s = BUSY;
        mem_en     = 1'b1;
        mem_we     = d_we;
        mem_size   = d_size;
        mem_addr   = d_addr;
        mem_wdata  = d_wdata;
      end
    end else if (gnt_if_s) begin
      if_gnt        = 1'b1;
      owner_nx_s    = OWN_IF;
      is_write_nx_s = 1'b0;
      cnt_nx_s      = 3'd0;
      state_nx_s    = BUSY;
      mem_en        = 1'b1;
      mem_size      = 2'b10;
      mem_addr      = if_addr;
    end else begin
      mem_en = 1'b0;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed self-checking bench for unified_mem_arbiter (MEM_LATENCY = 2).
module tb_unified_mem_arbiter;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [1:0]  d_size;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, d_err, mem_en, mem_we;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [1:0]  mem_size;

  int errors = 0;
  int checks = 0;

  unified_mem_arbiter #(.MEM_LATENCY(LAT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_if_gnt"}, {31'd0, if_gnt}, 32'd0);
    chk({tag, "_d_gnt"}, {31'd0, d_gnt}, 32'd0);
    chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
    chk({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
    chk({tag, "_d_err"}, {31'd0, d_err}, 32'd0);
    chk({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  // Inputs change on the falling edge. Outputs are sampled 1 time unit later.
  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_size = 2'b10;
    if_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; mem_rdata = 32'hCAFE_0010;

    // Hold reset while a fetch is pending: nothing may be granted.
    cyc(); if_req = 1'b1; if_addr = 32'h10; #1;
    chk_quiet("rst");
    cyc(); #1;
    chk("rst_hold_if_gnt", {31'd0, if_gnt}, 32'd0);

    // Fetch only: grant in the release cycle, rvalid LAT cycles later.
    cyc(); rst = 1'b1; #1;
    chk("f_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("f_mem_en", {31'd0, mem_en}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h10);
    chk("f_mem_size", {30'd0, mem_size}, 32'd2);
    chk("f_mem_we", {31'd0, mem_we}, 32'd0);
    cyc(); if_req = 1'b0; #1;
    chk("f_wait_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk("f_wait_mem_en", {31'd0, mem_en}, 32'd0);
    cyc(); #1;
    chk("f_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("f_if_rdata", if_rdata, 32'hCAFE_0010);
    chk("f_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    cyc(); #1;
    chk("f_after_rvalid", {31'd0, if_rvalid}, 32'd0);

    // Contention: the load wins. The fetch is granted in the load's completion cycle.
    cyc(); if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_we = 1'b0;
    d_size = 2'b10; d_addr = 32'h20; mem_rdata = 32'h1111_2222; #1;
    chk("c_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("c_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("c_mem_addr", mem_addr, 32'h20);
    cyc(); d_req = 1'b0; #1;
    chk("c_busy_if_gnt", {31'd0, if_gnt}, 32'd0);
    chk("c_busy_mem_en", {31'd0, mem_en}, 32'd0);
    cyc(); #1;
    chk("c_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("c_d_rdata", d_rdata, 32'h1111_2222);
    chk("c_if_gnt2", {31'd0, if_gnt}, 32'd1);
    chk("c_mem_addr2", mem_addr, 32'h30);
    chk("c_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    cyc(); if_req = 1'b0; mem_rdata = 32'h3333_4444; #1;
    chk("c_gap_rvalid", {31'd0, if_rvalid}, 32'd0);
    cyc(); #1;
    chk("c_if_rvalid2", {31'd0, if_rvalid}, 32'd1);
    chk("c_if_rdata2", if_rdata, 32'h3333_4444);
    chk("c_d_rvalid2", {31'd0, d_rvalid}, 32'd0);

    // Store: a single write cycle carries the store's address and data. The acknowledge comes LAT cycles later.
    cyc(); d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h44;
    d_wdata = 32'hDEAD_BEEF; #1;
    chk("s_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("s_mem_we", {31'd0, mem_we}, 32'd1);
    chk("s_mem_addr", mem_addr, 32'h44);
    chk("s_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    cyc(); d_req = 1'b0; d_we = 1'b0; #1;
    chk("s_mem_we_off", {31'd0, mem_we}, 32'd0);
    chk("s_mem_wdata_off", mem_wdata, 32'd0);
    cyc(); #1;
    chk("s_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("s_d_err", {31'd0, d_err}, 32'd0);

    // Misaligned half-word load at 0x23. A fetch is waiting behind it.
    cyc(); d_req = 1'b1; d_we = 1'b0; d_size = 2'b01; d_addr = 32'h23;
    if_req = 1'b1; if_addr = 32'h50; #1;
    chk("m_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("m_mem_en", {31'd0, mem_en}, 32'd0);
    chk("m_if_gnt", {31'd0, if_gnt}, 32'd0);
    cyc(); d_req = 1'b0; #1;
    chk("m_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("m_d_err", {31'd0, d_err}, 32'd1);
    chk("m_d_rdata", d_rdata, 32'd0);
    chk("m_err_if_gnt", {31'd0, if_gnt}, 32'd0);
    cyc(); #1;
    chk("m_if_gnt_after", {31'd0, if_gnt}, 32'd1);
    chk("m_mem_addr", mem_addr, 32'h50);
    chk("m_d_err_clear", {31'd0, d_err}, 32'd0);
    cyc(); if_req = 1'b0; #1;
    cyc(); #1;
    chk("m_if_rvalid", {31'd0, if_rvalid}, 32'd1);

    // A misaligned word store must not write the memory.
    cyc(); d_req = 1'b1; d_we = 1'b1; d_size = 2'b10; d_addr = 32'h46; #1;
    chk("mw_d_gnt", {31'd0, d_gnt}, 32'd1);
    chk("mw_mem_we", {31'd0, mem_we}, 32'd0);
    cyc(); d_req = 1'b0; d_we = 1'b0; #1;
    chk("mw_d_err", {31'd0, d_err}, 32'd1);
    cyc(); #1;

    // Reset while a load is outstanding: that load never gets an rvalid.
    cyc(); d_req = 1'b1; d_size = 2'b10; d_addr = 32'h60; #1;
    chk("r_d_gnt", {31'd0, d_gnt}, 32'd1);
    cyc(); d_req = 1'b0; if_req = 1'b1; if_addr = 32'h70; #1;
    rst = 1'b0; #1;
    chk_quiet("r_mid");
    cyc(); #1;
    chk("r_hold_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    cyc(); rst = 1'b1; #1;
    chk("r_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("r_mem_addr", mem_addr, 32'h70);
    chk("r_d_rvalid", {31'd0, d_rvalid}, 32'd0);
    cyc(); if_req = 1'b0; #1;
    chk("r_d_rvalid2", {31'd0, d_rvalid}, 32'd0);
    cyc(); #1;
    chk("r_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("r_d_rvalid3", {31'd0, d_rvalid}, 32'd0);

    // Both ports request continuously. One grant lands every LAT cycles.
    cyc(); if_req = 1'b1; if_addr = 32'h80; d_req = 1'b1; d_we = 1'b0;
    d_size = 2'b10; d_addr = 32'h90;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef UMA_RR_ARB_EN
      chk($sformatf("arb_d_gnt_%0d", k), {31'd0, d_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("arb_if_gnt_%0d", k), {31'd0, if_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
`else
      chk($sformatf("arb_d_gnt_%0d", k), {31'd0, d_gnt}, 32'd1);
      chk($sformatf("arb_if_gnt_%0d", k), {31'd0, if_gnt}, 32'd0);
`endif
      chk($sformatf("arb_both_rvalid_%0d", k), {31'd0, if_rvalid & d_rvalid}, 32'd0);
      cyc(); #1;
      chk($sformatf("arb_gap_%0d", k), {31'd0, if_gnt | d_gnt}, 32'd0);
      cyc();
    end
    if_req = 1'b0; d_req = 1'b0;
    cyc(); cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
